// File: rtl/memb_pkg.sv
// Shared definitions for the memory port-B arbiter: bus widths, the
// arbiter state encoding and the queued IO write record.
package memb_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;

  // Latency from the registered port-B issue to disp_rvalid, in cycles.
  localparam int RD_STAGES = 1;

  // One-hot style encoding so each issued-op flag is a single state bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DISP = 2'b01,
    ST_IO   = 2'b10
  } st_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } io_wr_t;

endpackage

// File: rtl/io_wr_fifo.sv
// IO write FIFO: holds {addr, data} pairs until the arbiter issues them
// on port B. FIFO_DEPTH must be a power of two so the pointers wrap by
// simple overflow; a separate level count distinguishes full from empty.
module io_wr_fifo
  import memb_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  io_wr_t           wdata,
  input  logic             pop,
  output io_wr_t           rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  io_wr_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since only written slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap modulo FIFO_DEPTH; push+pop together leave level unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/memb_arbiter.sv
// Memory port-B arbiter: shares one port between pipelined display reads
// and queued IO writes. At most one op is granted per cycle, decided
// combinationally; port-B address/data/write-enable are registered, and
// read data returns two cycles after the grant.
// Optional starvation guard: define MEMB_STARVE_GUARD_EN to force an IO
// write through after STARVE_LIMIT display grants with IO pending.
module memb_arbiter
  import memb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              io_req,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_data,
  output logic              io_ready,
  output logic [ADDR_W-1:0] addressS,
  output logic              wrIO,
  output logic [DATA_W-1:0] IOdata,
  input  logic [DATA_W-1:0] dataOutS
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  st_e              state;
  st_e              nxt_state;
  io_wr_t           fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [LVL_W-1:0] fifo_level;
  logic             starve_hit;
  logic [RD_STAGES:0] vld_pipe;

  // Level is exposed for observability; arbitration only needs full/empty.
  logic unused_level;
  assign unused_level = ^fifo_level;

  // io_ready is a pure function of full so a same-cycle pop never lets a
  // push slip into a full FIFO; held low while reset is asserted.
  assign io_ready  = rst && !fifo_full;
  assign fifo_push = io_req && io_ready;

  io_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (io_wr_t'{addr: io_addr, data: io_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef MEMB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count display grants made while IO waits; any IO issue or an empty
  // FIFO means nothing is being starved, so the count restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         starve_cnt <= '0;
    else if (fifo_pop || fifo_empty)  starve_cnt <= '0;
    else if (disp_gnt)                starve_cnt <= starve_cnt + 1'b1;
  end
`else
  // Strict display priority: the FIFO is never forced ahead of a display
  // request. STARVE_LIMIT only matters when the guard is built in.
  logic unused_cfg;
  assign unused_cfg = (STARVE_LIMIT < 0);
  assign starve_hit = 1'b0;
`endif

  // State register: records which op was issued on port B last cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt_state;
  end

  // Next state is this cycle's grant: display first, unless starving IO.
  always_comb begin
    nxt_state = ST_IDLE;
    if (!rst)                                         nxt_state = ST_IDLE;
    else if (!fifo_empty && (starve_hit || !disp_req)) nxt_state = ST_IO;
    else if (disp_req)                                 nxt_state = ST_DISP;
  end

  // Grant strobes decoded from the grant decision.
  always_comb begin
    disp_gnt = 1'b0;
    fifo_pop = 1'b0;
    case (nxt_state)
      ST_DISP: disp_gnt = 1'b1;
      ST_IO:   fifo_pop = 1'b1;
      default: ;
    endcase
  end

  // Port-B address/data registers; they hold when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addressS <= '0;
      IOdata   <= '0;
    end else begin
      case (nxt_state)
        ST_DISP: addressS <= disp_addr;
        ST_IO: begin
          addressS <= fifo_head.addr;
          IOdata   <= fifo_head.data;
        end
        default: ;
      endcase
    end
  end

  // Write enable comes straight from the IO state bit, so it is a flop
  // output and pulses for exactly the cycle after an IO grant.
  assign wrIO = state[1];

  // Read valid shift register: grant -> issued -> data returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[RD_STAGES-1:0], disp_gnt};
  end

  // Memory data is already a cycle behind addressS, so it passes through
  // unregistered to meet the two-cycle read latency.
  assign disp_rvalid = vld_pipe[RD_STAGES];
  assign disp_rdata  = disp_rvalid ? dataOutS : '0;

endmodule

// File: tb/tb_memb_arbiter.sv
// Bench for memb_arbiter: a queue-based model of the arbiter checks every
// output on every cycle, and directed scenarios pin hand-computed values.
// Builds with or without MEMB_STARVE_GUARD_EN.
module tb_memb_arbiter;
  import memb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef MEMB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        io_req;
  logic [15:0] io_addr;
  logic [7:0]  io_data;
  logic        io_ready;
  logic [15:0] addressS;
  logic        wrIO;
  logic [7:0]  IOdata;
  logic [7:0]  dataOutS = 8'h00;

  int total = 0;
  int bad   = 0;

  memb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .io_req(io_req), .io_addr(io_addr), .io_data(io_data), .io_ready(io_ready),
    .addressS(addressS), .wrIO(wrIO), .IOdata(IOdata), .dataOutS(dataOutS)
  );

  always #5 clk = ~clk;

  // Memory contents as a fixed function of address.
  function automatic logic [7:0] mbyte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Port-B memory: read data one cycle after the address.
  always @(posedge clk) dataOutS <= mbyte(addressS);

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  io_wr_t      mq[$];
  int          m_cnt;
  bit          m_rd, m_wr, r_vld;
  logic [15:0] m_addr, r_addr;
  logic [7:0]  m_iod;

  always @(negedge clk) begin
    bit rdy, starve, g_io, g_disp;
    if (!rst) begin
      chk("rst_gnt",    disp_gnt, 0);
      chk("rst_rvalid", disp_rvalid, 0);
      chk("rst_rdata",  disp_rdata, 0);
      chk("rst_ready",  io_ready, 0);
      chk("rst_addr",   addressS, 0);
      chk("rst_wr",     wrIO, 0);
      chk("rst_iod",    IOdata, 0);
      mq.delete();
      m_cnt = 0; m_rd = 0; m_wr = 0; r_vld = 0;
      m_addr = '0; r_addr = '0; m_iod = '0;
    end else begin
      rdy    = mq.size() < DEPTH;
      starve = GUARD && (m_cnt == LIMIT);
      g_io   = (mq.size() > 0) && (starve || !disp_req);
      g_disp = disp_req && !g_io;
      chk("m_ready",  io_ready, rdy);
      chk("m_gnt",    disp_gnt, g_disp);
      chk("m_wr",     wrIO, m_wr);
      chk("m_addr",   addressS, m_addr);
      chk("m_iod",    IOdata, m_iod);
      chk("m_rvalid", disp_rvalid, r_vld);
      chk("m_rdata",  disp_rdata, r_vld ? mbyte(r_addr) : 8'h00);
      r_vld  = m_rd;
      r_addr = m_addr;
      m_rd   = g_disp;
      m_wr   = g_io;
      if (g_disp) m_addr = disp_addr;
      if (g_io) begin
        m_addr = mq[0].addr;
        m_iod  = mq[0].data;
      end
      if (GUARD) begin
        if (g_io || mq.size() == 0) m_cnt = 0;
        else if (g_disp)            m_cnt++;
      end
      if (g_io) void'(mq.pop_front());
      if (io_req && rdy) mq.push_back(io_wr_t'{addr: io_addr, data: io_data});
    end
  end

  // Record every write pulse seen on port B.
  io_wr_t got_wr[$];
  always @(negedge clk) if (rst && wrIO) got_wr.push_back(io_wr_t'{addr: addressS, data: IOdata});

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k = 0;
    while (got_wr.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [15:0] a, input logic [7:0] d);
    if (idx < got_wr.size()) begin
      chk({nm, "_addr"}, got_wr[idx].addr, a);
      chk({nm, "_data"}, got_wr[idx].data, d);
    end else begin
      chk({nm, "_missing"}, idx, got_wr.size());
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; disp_req = 0; disp_addr = '0; io_req = 0; io_addr = '0; io_data = '0;
    tick(); tick(); settle();
    chk("rst_lit_ready", io_ready, 0);
    chk("rst_lit_wr", wrIO, 0);
    tick(); rst = 1'b1; settle();
    chk("rel_ready", io_ready, 1);

    // Single display read of 0x1234.
    tick(); disp_req = 1; disp_addr = 16'h1234; settle();
    chk("rd_gnt", disp_gnt, 1);
    tick(); disp_req = 0; settle();
    chk("rd_addr", addressS, 16'h1234);
    chk("rd_wr", wrIO, 0);
    tick(); settle();
    chk("rd_rvalid", disp_rvalid, 1);
    chk("rd_rdata", disp_rdata, 8'h7C);
    tick(); tick();

    // IO burst of 5 with no display traffic.
    got_wr.delete();
    for (int i = 0; i < 5; i++) begin
      io_req = 1; io_addr = 16'(16'hA000 + i); io_data = 8'(8'h10 + i);
      settle();
      chk("burst_ready", io_ready, 1);
      tick();
    end
    io_req = 0;
    wait_wr(5, 20);
    chk("burst_cnt", got_wr.size(), 5);
    for (int i = 0; i < 5; i++) chk_wr("burst", i, 16'(16'hA000 + i), 8'(8'h10 + i));
    tick(); tick();

`ifndef MEMB_STARVE_GUARD_EN
    // Full FIFO under strict display priority.
    got_wr.delete();
    disp_req = 1; disp_addr = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      io_req = 1; io_addr = 16'(16'hB000 + i); io_data = 8'(8'h20 + i);
      settle();
      chk("full_ready", io_ready, 1);
      tick();
    end
    io_addr = 16'hB004; io_data = 8'h24; settle();
    chk("full_notready", io_ready, 0);
    tick(); tick(); settle();
    chk("full_stall", io_ready, 0);
    chk("full_nowr", got_wr.size(), 0);
    disp_req = 0; #1;
    chk("full_nobypass", io_ready, 0);
    tick(); settle();
    chk("full_accept", io_ready, 1);
    tick(); io_req = 0;
    wait_wr(5, 20);
    chk("full_cnt", got_wr.size(), 5);
    for (int i = 0; i < 5; i++) chk_wr("full", i, 16'(16'hB000 + i), 8'(8'h20 + i));
    tick(); tick();
`else
    // Starvation guard: one write behind a held display request.
    got_wr.delete();
    disp_req = 1; disp_addr = 16'h3000; io_req = 1; io_addr = 16'hC000; io_data = 8'h5E;
    settle();
    chk("starve_push_gnt", disp_gnt, 1);
    tick(); io_req = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (!disp_gnt) break;
      n++;
      tick();
    end
    chk("starve_ngnt", n, LIMIT);
    chk("starve_gnt0", disp_gnt, 0);
    tick(); settle();
    chk("starve_wr", wrIO, 1);
    chk("starve_addr", addressS, 16'hC000);
    disp_req = 0;
    tick(); tick(); tick();
`endif

    // Reset with 3 queued writes and 2 reads in flight.
    got_wr.delete();
    disp_req = 1; disp_addr = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      io_req = 1; io_addr = 16'(16'hD000 + i); io_data = 8'(8'h30 + i);
      tick();
    end
    io_req = 0; disp_req = 0; rst = 1'b0;
    tick(); tick(); rst = 1'b1; settle();
    chk("rstmid_ready", io_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("rstmid_wr", wrIO, 0);
      chk("rstmid_rvalid", disp_rvalid, 0);
      tick(); settle();
    end
    chk("rstmid_nowr", got_wr.size(), 0);
    tick();

    // Push and pop together at level 2.
    got_wr.delete();
    disp_req = 1; disp_addr = 16'h5000;
    for (int i = 0; i < 2; i++) begin
      io_req = 1; io_addr = 16'(16'hE000 + i); io_data = 8'(8'h40 + i);
      tick();
    end
    settle();
    chk("pp_lvl_before", dut.u_fifo.level, 2);
    disp_req = 0; io_addr = 16'hE002; io_data = 8'h42;
    tick(); io_req = 0; settle();
    chk("pp_lvl_after", dut.u_fifo.level, 2);
    wait_wr(3, 20);
    chk("pp_cnt", got_wr.size(), 3);
    for (int i = 0; i < 3; i++) chk_wr("pp", i, 16'(16'hE000 + i), 8'(8'h40 + i));

    // Mixed traffic; the per-cycle model does the checking.
    for (int i = 0; i < 40; i++) begin
      disp_req  = ((i % 3) != 0);
      disp_addr = 16'(16'h6000 + 7 * i);
      io_req    = ((i % 4) < 2);
      io_addr   = 16'(16'hF000 + i);
      io_data   = 8'(8'h80 + i);
      tick();
    end
    disp_req = 0; io_req = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memb_arbiter.md
MEMB_ARBITER -- requirements
Module: memb_arbiter

Interface
REQ-001 The parameter FIFO_DEPTH SHALL default to 4 and set the IO write FIFO depth (power of two, 2..16).
REQ-002 The parameter STARVE_LIMIT SHALL default to 8 and set the maximum consecutive display grants while IO is pending.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 disp_req  input  1  display read request.
REQ-006 disp_addr  input  16  display read address.
REQ-007 disp_gnt  output  1  display request accepted this cycle.
REQ-008 disp_rvalid  output  1  disp_rdata valid.
REQ-009 disp_rdata  output  8  display read data.
REQ-010 io_req  input  1  IO write request.
REQ-011 io_addr  input  16  IO write address.
REQ-012 io_data  input  8  IO write data.
REQ-013 io_ready  output  1  IO FIFO can accept a write.
REQ-014 addressS  output  16  memory port-B address, registered.
REQ-015 wrIO  output  1  memory port-B write enable, registered.
REQ-016 IOdata  output  8  memory port-B write data, registered.
REQ-017 dataOutS  input  8  memory port-B read data, valid one cycle after addressS.

Function
REQ-018 IO write handshake: transfer SHALL occur on a cycle with io_req=1 and io_ready=1; the {io_addr, io_data} pair is pushed into the FIFO.
REQ-019 io_ready SHALL equal NOT full; it SHALL NOT depend on a pop in the same cycle (no bypass when full).
REQ-020 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the level unchanged.
REQ-021 Exactly one port-B operation SHALL be issued per cycle at most; the grant is decided combinationally in cycle t.
REQ-022 Priority: disp_req SHALL win over a non-empty FIFO, unless the starvation guard is active (REQ-031).
REQ-023 disp_gnt SHALL be high in cycle t when the display wins; a display request that is not granted SHALL hold until granted.
REQ-024 A grant in cycle t SHALL drive addressS/wrIO/IOdata at t+1; for a read, wrIO=0 and disp_rvalid=1 with disp_rdata=dataOutS at t+2 (latency 2, one read per cycle, fully pipelined).
REQ-025 An IO pop in cycle t SHALL drive addressS=fifo addr, IOdata=fifo data and wrIO=1 for exactly one cycle at t+1.
REQ-026 With no grant, wrIO SHALL be 0; addressS and IOdata SHALL hold their previous values.
REQ-027 State register states: ST_IDLE (no op issued), ST_DISP (display read issued), ST_IO (IO write issued); the next state SHALL equal the grant made in the current cycle.
REQ-028 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with a separate level count 0..FIFO_DEPTH.

Reset
REQ-029 While rst=0: disp_gnt=0, disp_rvalid=0, disp_rdata=0, io_ready=0, addressS=0, wrIO=0, IOdata=0, FIFO empty, state ST_IDLE, starvation counter 0.
REQ-030 Reset mid-operation SHALL discard queued writes and in-flight reads; no wrIO pulse and no disp_rvalid SHALL follow deassertion until new grants occur; io_ready SHALL be 1 on the first cycle after deassertion.

Configuration
REQ-031 With MEMB_STARVE_GUARD_EN defined: a counter SHALL increment on each display grant while the FIFO is non-empty and clear on any IO grant or when the FIFO is empty; at count=STARVE_LIMIT the FIFO SHALL win that cycle even if disp_req=1.
REQ-032 Without MEMB_STARVE_GUARD_EN: strict display priority SHALL apply, and no counter logic SHALL be synthesized.

Structure
REQ-033 Package memb_pkg SHALL hold ADDR_W=16, DATA_W=8 and the state encoding ST_IDLE/ST_DISP/ST_IO.
REQ-034 The FIFO SHALL be a sub-module io_wr_fifo (push/pop, full/empty, level); arbitration, the state machine and output registers SHALL reside in memb_arbiter.

Verification
REQ-035 Single read: disp_req with disp_addr=0x1234 for 1 cycle -> disp_gnt at t, addressS=0x1234 and wrIO=0 at t+1, disp_rvalid at t+2 with the model byte.
REQ-036 IO burst: 5 writes back-to-back with disp_req=0 -> io_ready stays 1, five wrIO pulses carry the correct addr/data in order.
REQ-037 Full FIFO: disp_req held 1 with the guard disabled, 5 IO writes -> io_ready=0 after the 4th, the 5th stalls, and writes drain in order after disp_req drops.
REQ-038 Starvation: guard enabled, disp_req held 1, 1 IO write -> the write is issued after exactly 8 display grants, and disp_gnt=0 in that cycle.
REQ-039 Reset mid-stream: assert rst with 3 queued writes and 2 reads in flight -> no wrIO and no disp_rvalid after release, and io_ready=1.
REQ-040 Simultaneous push/pop at level 2 -> level stays 2 and data order is preserved.
